// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences operand reads, skew, clear/accumulate and the result handshake for a 2x2 systolic array
module systolic_ctrl #(
    parameter int datawith   = 16,
    parameter int array_size = 2,
    parameter int addr_w     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [addr_w-1:0]       k_len,
    output logic                    busy,
    output logic                    buf_rd_en,
    output logic [addr_w-1:0]       buf_rd_addr,
    input  logic [2*datawith-1:0]   a_rd_data,
    input  logic [2*datawith-1:0]   b_rd_data,
    output logic [2*datawith-1:0]   arr_data_in,
    output logic [2*datawith-1:0]   arr_weight_in,
    output logic                    arr_en,
    output logic                    arr_clear,
    input  logic [4*datawith-1:0]   arr_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*datawith-1:0]   res_data
);
    localparam int drain_n = 2*array_size-1;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPT, DONE} state_t;
    state_t state, state_d;
    logic [addr_w-1:0] k_q, addr_q;
    logic [1:0] drain_q;
    logic rd_en_d;
    logic [datawith-1:0] a1_q, b1_q;
    logic [4*datawith-1:0] res_q;
    logic feed_last, drain_last;
    assign feed_last  = addr_q == k_q - addr_w'(1);
    assign drain_last = drain_q == 2'(drain_n - 1);
    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end
    // next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = (start && k_len != '0) ? CLEAR : IDLE;
            CLEAR:   state_d = FEED;
            FEED:    state_d = feed_last ? DRAIN : FEED;
            DRAIN:   state_d = drain_last ? CAPT : DRAIN;
            CAPT:    state_d = DONE;
            DONE:    state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // job length, read address, drain counter, skew stages and result latch
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q     <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            rd_en_d <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            res_q   <= '0;
        end else begin
            k_q     <= (state == IDLE && start && k_len != '0) ? k_len : k_q;
            addr_q  <= (state == FEED && !feed_last) ? addr_q + addr_w'(1) : '0;
            drain_q <= (state == DRAIN) ? drain_q + 2'd1 : 2'd0;
            rd_en_d <= state == FEED;
            a1_q    <= rd_en_d ? a_rd_data[2*datawith-1:datawith] : '0;
            b1_q    <= rd_en_d ? b_rd_data[2*datawith-1:datawith] : '0;
            res_q   <= (state == CAPT) ? arr_result : res_q;
        end
    end
    assign busy          = state != IDLE;
    assign buf_rd_en     = state == FEED;
    assign buf_rd_addr   = addr_q;
    assign arr_clear     = state == CLEAR;
    assign arr_en        = rd_en_d || state == DRAIN;
    assign arr_data_in   = {a1_q, rd_en_d ? a_rd_data[datawith-1:0] : {datawith{1'b0}}};
    assign arr_weight_in = {b1_q, rd_en_d ? b_rd_data[datawith-1:0] : {datawith{1'b0}}};
    assign res_valid     = state == DONE;
    assign res_data      = res_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench with operand buffer and 2x2 array models around systolic_ctrl
module tb_systolic_ctrl;
    logic clk, rst, start, res_ready;
    logic [7:0] k_len, buf_rd_addr;
    logic busy, buf_rd_en, arr_en, arr_clear, res_valid;
    logic [31:0] a_rd_data, b_rd_data, arr_data_in, arr_weight_in;
    logic [63:0] arr_result, res_data;

    systolic_ctrl #(.datawith(16), .array_size(2), .addr_w(8)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .arr_data_in(arr_data_in), .arr_weight_in(arr_weight_in),
        .arr_en(arr_en), .arr_clear(arr_clear), .arr_result(arr_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // operand buffer model with one-cycle read latency
    logic [15:0] amem [2][256];
    logic [15:0] bmem [256][2];
    initial begin a_rd_data = 0; b_rd_data = 0; end
    always @(posedge clk) if (buf_rd_en) begin
        a_rd_data <= {amem[1][buf_rd_addr], amem[0][buf_rd_addr]};
        b_rd_data <= {bmem[buf_rd_addr][1], bmem[buf_rd_addr][0]};
    end

    // output-stationary 2x2 array model: A flows right, B flows down
    logic [15:0] acc [2][2], ar [2][2], br [2][2];
    function automatic logic [15:0] ain(input int i, input int j);
        return j == 0 ? arr_data_in[16*i +: 16] : ar[i][0];
    endfunction
    function automatic logic [15:0] bin(input int i, input int j);
        return i == 0 ? arr_weight_in[16*j +: 16] : br[0][j];
    endfunction
    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                acc[i][j] <= arr_clear ? 16'd0 : arr_en ? acc[i][j] + ain(i, j) * bin(i, j) : acc[i][j];
                ar[i][j]  <= ain(i, j);
                br[i][j]  <= bin(i, j);
            end
    assign arr_result = {acc[0][0], acc[0][1], acc[1][0], acc[1][1]};

    function automatic logic [63:0] matmul(input int k);
        logic [15:0] c [2][2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                c[i][j] = 0;
                for (int m = 0; m < k; m++) c[i][j] = c[i][j] + amem[i][m] * bmem[m][j];
            end
        return {c[0][0], c[0][1], c[1][0], c[1][1]};
    endfunction

    logic [63:0] sb [$];

    // per-cycle protocol monitor relative to the accept cycle t0
    bit mon_on = 0;
    int t0 = 0, kk = 0, rel;
    int rd_err, clr_err, en_err, en_cnt, lane_err, ctl_err;
    bit ex_rd, l0, l1;
    logic [31:0] e;
    always @(negedge clk) if (mon_on) begin
        rel = cyc - t0;
        ex_rd = rel >= 2 && rel <= kk + 1;
        if (buf_rd_en !== ex_rd || buf_rd_addr !== (ex_rd ? 8'(rel - 2) : 8'd0)) rd_err++;
        if (arr_clear !== (rel == 1)) clr_err++;
        if (arr_en !== (rel >= 3 && rel <= kk + 4)) en_err++;
        if (arr_en) en_cnt++;
        l0 = rel >= 3 && rel <= kk + 2;
        l1 = rel >= 4 && rel <= kk + 3;
        e = {l1 ? amem[1][rel-4] : 16'd0, l0 ? amem[0][rel-3] : 16'd0};
        if (arr_data_in !== e) lane_err++;
        e = {l1 ? bmem[rel-4][1] : 16'd0, l0 ? bmem[rel-3][0] : 16'd0};
        if (arr_weight_in !== e) lane_err++;
        if (rel <= kk + 6 && busy !== (rel >= 1)) ctl_err++;
        if (rel < kk + 6 && res_valid) ctl_err++;
    end

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({busy, buf_rd_en, arr_en, arr_clear, res_valid}), 0);
        check({tag, "_addr"}, 64'(buf_rd_addr), 0);
        check({tag, "_stream"}, {arr_data_in, arr_weight_in}, 0);
        check({tag, "_res"}, res_data, 0);
    endtask

    task automatic run_job(input int k, input int hold, input bit noise, input logic [63:0] want);
        logic [63:0] w;
        int waited, herr;
        sb.push_back(want);
        @(posedge clk); #1;
        start = 1; k_len = 8'(k); t0 = cyc; kk = k;
        rd_err = 0; clr_err = 0; en_err = 0; en_cnt = 0; lane_err = 0; ctl_err = 0;
        mon_on = 1;
        @(posedge clk); #1;
        start = 0;
        if (noise) k_len = 8'd7;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (noise) start = (cyc - t0 == 3);
        end while (!res_valid && waited < k + 20);
        check("valid", 64'(res_valid), 1);
        check("latency", 64'(cyc - t0), 64'(k + 6));
        w = '1;
        if (sb.size() != 0) w = sb.pop_front();
        check("res_data", res_data, w);
        herr = 0;
        for (int i = 0; i < hold; i++) begin
            if (noise) start = (i == 0);
            @(negedge clk);
            if (!res_valid || res_data !== w) herr++;
        end
        check("hold", 64'(herr), 0);
        res_ready = 1;
        start = noise;
        @(negedge clk);
        check("handshake", 64'({res_valid, busy}), 0);
        res_ready = 0; start = 0; mon_on = 0;
        check("rd_seq", 64'(rd_err), 0);
        check("clear", 64'(clr_err), 0);
        check("en_win", 64'(en_err), 0);
        check("en_cnt", 64'(en_cnt), 64'(k + 2));
        check("lanes", 64'(lane_err), 0);
        check("ctl", 64'(ctl_err), 0);
    endtask

    task automatic load_basic();
        amem[0][0] = 1; amem[0][1] = 2; amem[1][0] = 3; amem[1][1] = 4;
        bmem[0][0] = 5; bmem[0][1] = 6; bmem[1][0] = 7; bmem[1][1] = 8;
    endtask

    int bad;
    initial begin
        rst = 0; start = 0; k_len = 0; res_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1;
        load_basic();
        run_job(2, 0, 0, {16'd19, 16'd22, 16'd43, 16'd50});
        // zero-length requests must not start a job
        bad = 0;
        k_len = 0; start = 1;
        repeat (4) begin
            @(negedge clk);
            if (busy || buf_rd_en || arr_clear) bad++;
        end
        start = 0;
        check("k0_ignored", 64'(bad), 0);
        // stray starts during FEED, DONE and the handshake cycle, k_len changed mid-job
        for (int m = 0; m < 3; m++) begin
            amem[0][m] = 16'($urandom); amem[1][m] = 16'($urandom);
            bmem[m][0] = 16'($urandom); bmem[m][1] = 16'($urandom);
        end
        run_job(3, 2, 1, matmul(3));
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || res_valid) bad++;
        end
        check("single_result", 64'(bad) + 64'(sb.size()), 0);
        // backpressure
        load_basic();
        run_job(2, 10, 0, {16'd19, 16'd22, 16'd43, 16'd50});
        // back-to-back jobs
        amem[0][0] = 2; amem[1][0] = 3; bmem[0][0] = 4; bmem[0][1] = 5;
        run_job(1, 0, 0, {16'd8, 16'd10, 16'd12, 16'd15});
        for (int m = 0; m < 3; m++) begin
            amem[0][m] = 1; amem[1][m] = 1; bmem[m][0] = 1; bmem[m][1] = 1;
        end
        run_job(3, 0, 0, {16'd3, 16'd3, 16'd3, 16'd3});
        // abort at t0+4 of a K=4 job
        @(posedge clk); #1;
        start = 1; k_len = 4;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check_zero("abort");
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (arr_en || buf_rd_en || busy) bad++;
        end
        check("abort_quiet", 64'(bad), 0);
        load_basic();
        run_job(2, 0, 0, {16'd19, 16'd22, 16'd43, 16'd50});
        // maximum K with address-tagged operands
        for (int m = 0; m < 256; m++) begin
            amem[0][m] = 16'(m); amem[1][m] = 16'(m);
            bmem[m][0] = 16'(m); bmem[m][1] = 16'(m);
        end
        run_job(255, 0, 0, matmul(255));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
